// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-in / datapath-control bundle of the core sequencer
interface instr_sequencer_if #(
  parameter int INSTW = 16,
  parameter int RSELW = 3,
  parameter int ADDRW = 7
);
  logic [INSTW-1:0] instruction;
  logic             run;
  logic             hold;
  logic             readEn;
  logic             writeEn;
  logic [RSELW-1:0] regANum;
  logic [RSELW-1:0] regBNum;
  logic [RSELW-1:0] regCNum;
  logic [3:0]       aluFSL;
  logic             opLatch;
  logic             resLatch;
  logic             sregLatch;
  logic [1:0]       wbSel;
  logic [7:0]       immValue;
  logic             addrLatch;
  logic             addrSel;
  logic [ADDRW-1:0] lineField;
  logic             memRead;
  logic             memWrite;
  logic             memInLatch;
  logic             memInSel;
  logic             retire;
  logic             busy;
  modport master (
    input  instruction, run,
    output hold, readEn, writeEn, regANum, regBNum, regCNum, aluFSL, opLatch, resLatch,
           sregLatch, wbSel, immValue, addrLatch, addrSel, lineField, memRead, memWrite,
           memInLatch, memInSel, retire, busy
  );
  modport slave (
    output instruction, run,
    input  hold, readEn, writeEn, regANum, regBNum, regCNum, aluFSL, opLatch, resLatch,
           sregLatch, wbSel, immValue, addrLatch, addrSel, lineField, memRead, memWrite,
           memInLatch, memInSel, retire, busy
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM stepping a fixed micro-sequence per instruction class
module instr_sequencer #(
  parameter int INSTW = 16,
  parameter int RSELW = 3,
  parameter int ADDRW = 7
) (
  input logic clk,
  input logic resetN,
  instr_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DEC, RD, OPL, EX, WB, FLG, MADDR, MRD, MCAP, MDAT, MADDR2, MWR, END
  } state_t;
  state_t state, nxt;
  logic [INSTW-1:0] ir, irN;
  logic isAlu, isLdi, isLdd, isLdn, isSt, isMov;
  logic nAlu, nLdi, nLdd, nLdn, nSt, nMov;
  logic [RSELW-1:0] aN, bN, cN;
  logic [1:0] wbN;
  logic [ADDRW-1:0] lineN;
  always_comb begin
    irN = (state == FETCH && bus.run) ? bus.instruction : ir;
    isAlu = ir[15:14] == 2'b00;
    isLdi = ir[15:12] == 4'b0100;
    isLdd = ir[15:12] == 4'b0101;
    isLdn = ir[15:12] == 4'b0110;
    isSt  = ir[15:12] == 4'b0111;
    isMov = ir[15:14] == 2'b11;
    nAlu = irN[15:14] == 2'b00;
    nLdi = irN[15:12] == 4'b0100;
    nLdd = irN[15:12] == 4'b0101;
    nLdn = irN[15:12] == 4'b0110;
    nSt  = irN[15:12] == 4'b0111;
    nMov = irN[15:14] == 2'b11;
    case (state)
      FETCH:         nxt = bus.run ? DEC : FETCH;
      DEC:           nxt = (isAlu || isLdd || isLdn || isSt) ? RD : isLdi ? WB : isMov ? MADDR : END;
      RD:            nxt = isLdn ? MADDR : isSt ? MDAT : OPL;
      OPL:           nxt = isAlu ? EX : WB;
      EX:            nxt = WB;
      WB:            nxt = isAlu ? FLG : END;
      FLG:           nxt = END;
      MADDR:         nxt = MRD;
      MRD:           nxt = MCAP;
      MCAP:          nxt = isMov ? MADDR2 : WB;
      MADDR2, MDAT:  nxt = MWR;
      MWR:           nxt = END;
      default:       nxt = FETCH;
    endcase
    aN = nAlu ? irN[9:7] : nLdd ? irN[6:4] : nSt ? irN[2:0] : '0;
    bN = nAlu ? irN[6:4] : nLdn ? irN[9:7] : '0;
    cN = nAlu ? irN[3:1] : nLdi ? irN[2:0] : nLdd ? irN[9:7] : nLdn ? irN[6:4] : '0;
    wbN = nLdi ? 2'd1 : nLdd ? 2'd2 : nLdn ? 2'd3 : 2'd0;
    // lineField is loaded at DEC and only rewritten to the MOV destination entering MADDR2
    lineN = (nxt == MADDR2) ? ir[6:0] :
            (nxt == DEC) ? (nSt ? irN[9:3] : nMov ? irN[13:7] : '0) : bus.lineField;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= FETCH;
      ir <= '0;
      bus.hold <= 1'b1;
      bus.readEn <= 1'b0;
      bus.writeEn <= 1'b0;
      bus.regANum <= '0;
      bus.regBNum <= '0;
      bus.regCNum <= '0;
      bus.aluFSL <= '0;
      bus.opLatch <= 1'b0;
      bus.resLatch <= 1'b0;
      bus.sregLatch <= 1'b0;
      bus.wbSel <= '0;
      bus.immValue <= '0;
      bus.addrLatch <= 1'b0;
      bus.addrSel <= 1'b0;
      bus.lineField <= '0;
      bus.memRead <= 1'b0;
      bus.memWrite <= 1'b0;
      bus.memInLatch <= 1'b0;
      bus.memInSel <= 1'b0;
      bus.retire <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= nxt;
      ir <= irN;
      bus.hold <= nxt != END;
      bus.readEn <= nxt == RD;
      bus.writeEn <= nxt == WB;
      bus.regANum <= aN;
      bus.regBNum <= bN;
      bus.regCNum <= cN;
      bus.aluFSL <= irN[13:10];
      bus.opLatch <= nxt == OPL;
      bus.resLatch <= nxt == EX;
      bus.sregLatch <= nxt == FLG;
      bus.wbSel <= wbN;
      bus.immValue <= irN[10:3];
      bus.addrLatch <= nxt == MADDR || nxt == MADDR2;
      bus.addrSel <= nLdn;
      bus.lineField <= lineN;
      bus.memRead <= nxt == MRD;
      bus.memWrite <= nxt == MWR;
      bus.memInLatch <= nxt == MCAP || nxt == MDAT;
      bus.memInSel <= nMov;
      bus.retire <= nxt == END;
      bus.busy <= nxt != FETCH;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed per-class sequence checks with hand-computed expectations
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic resetN = 1'b1;
  int total = 0;
  int bad = 0;
  int cycles, nRd, nWr, nOpl, nRes, nSreg, nAl, nMrd, nMwr, nMcap, nRet, nHoldLow, nExcl, nDrift;
  int fRd, fWr, fSreg, fMrd, fMwr, fRet;
  logic [6:0] line0, line1;
  logic [2:0] a0, b0, c0;
  logic [1:0] wb0;
  instr_sequencer_if bus ();
  instr_sequencer dut (.clk(clk), .resetN(resetN), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Issue one instruction from FETCH and profile every cycle until it is back in FETCH
  task automatic runInstr(input logic [15:0] instr);
    cycles = 1;
    {nRd, nWr, nOpl, nRes, nSreg, nAl, nMrd, nMwr, nMcap, nRet, nHoldLow, nExcl, nDrift} = '0;
    {fRd, fWr, fSreg, fMrd, fMwr, fRet} = {6{-32'sd1}};
    line0 = '0;
    line1 = '0;
    bus.instruction = instr;
    bus.run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.run = 1'b0;
      if (!bus.busy) break;
      cycles++;
      if (k == 1) begin
        a0 = bus.regANum;
        b0 = bus.regBNum;
        c0 = bus.regCNum;
        wb0 = bus.wbSel;
      end else if (bus.regANum !== a0 || bus.regBNum !== b0 || bus.regCNum !== c0 || bus.wbSel !== wb0) nDrift++;
      if (int'(bus.readEn) + int'(bus.writeEn) + int'(bus.memRead) + int'(bus.memWrite) > 1) nExcl++;
      if (bus.readEn) begin nRd++; if (fRd < 0) fRd = k; end
      if (bus.writeEn) begin nWr++; if (fWr < 0) fWr = k; end
      if (bus.sregLatch) begin nSreg++; if (fSreg < 0) fSreg = k; end
      if (bus.memRead) begin nMrd++; if (fMrd < 0) fMrd = k; end
      if (bus.memWrite) begin nMwr++; if (fMwr < 0) fMwr = k; end
      if (bus.retire) begin nRet++; if (fRet < 0) fRet = k; end
      if (bus.opLatch) nOpl++;
      if (bus.resLatch) nRes++;
      if (bus.memInLatch) nMcap++;
      if (!bus.hold) nHoldLow++;
      if (bus.addrLatch) begin
        if (nAl == 0) line0 = bus.lineField; else line1 = bus.lineField;
        nAl++;
      end
    end
  endtask
  initial begin
    bus.instruction = '0;
    bus.run = 1'b0;
    #1 resetN = 1'b0;
    #10;
    chk("rst_hold", 32'(bus.hold), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_writeEn", 32'(bus.writeEn), 0);
    chk("rst_retire", 32'(bus.retire), 0);
    chk("rst_regC", 32'(bus.regCNum), 0);
    chk("rst_line", 32'(bus.lineField), 0);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    tick();
    tick();
    chk("park_busy", 32'(bus.busy), 0);
    chk("park_hold", 32'(bus.hold), 1);
    runInstr(16'h8000);
    chk("br_cycles", cycles, 3);
    chk("br_retire_at", fRet, 2);
    chk("br_strobes", nRd + nWr + nMrd + nMwr + nAl + nOpl + nMcap, 0);
    chk("br_holdlow", nHoldLow, 1);
    runInstr(16'h0392);
    chk("alu_cycles", cycles, 8);
    chk("alu_rd_at", fRd, 2);
    chk("alu_wr_at", fWr, 5);
    chk("alu_sreg_at", fSreg, 6);
    chk("alu_ret_at", fRet, 7);
    chk("alu_counts", {8'(nRd), 8'(nOpl), 8'(nRes), 8'(nWr)}, 32'h01010101);
    chk("alu_regs", {a0, b0, c0, wb0}, {3'd7, 3'd1, 3'd1, 2'd0});
    chk("alu_drift", nDrift, 0);
    chk("alu_excl", nExcl, 0);
    runInstr(16'h452B);
    chk("ldi_cycles", cycles, 4);
    chk("ldi_imm", 32'(bus.immValue), 32'hA5);
    chk("ldi_regC_wb", {c0, wb0}, {3'd3, 2'd1});
    chk("ldi_wr", {8'(nWr), 8'(fWr), 8'(nRd)}, {8'd1, 8'd2, 8'd0});
    chk("ldi_holdlow", nHoldLow, 1);
    runInstr(16'h5160);
    chk("ldd_cycles", cycles, 6);
    chk("ldd_regs", {a0, c0, wb0}, {3'd6, 3'd2, 2'd2});
    chk("ldd_counts", {8'(nRd), 8'(nOpl), 8'(nRes), 8'(nWr)}, 32'h01010001);
    runInstr(16'h6210);
    chk("ldn_cycles", cycles, 8);
    chk("ldn_regs", {b0, c0, wb0}, {3'd4, 3'd1, 2'd3});
    chk("ldn_addrSel", 32'(bus.addrSel), 1);
    chk("ldn_counts", {8'(nMrd), 8'(nMcap), 8'(nWr), 8'(nAl)}, 32'h01010101);
    chk("ldn_excl", nExcl, 0);
    runInstr(16'h7155);
    chk("st_cycles", cycles, 6);
    chk("st_line", 32'(bus.lineField), 32'h2A);
    chk("st_memInSel", 32'(bus.memInSel), 0);
    chk("st_regA", 32'(a0), 5);
    chk("st_mwr", {8'(nMwr), 8'(fMwr), 8'(nWr), 8'(nMcap)}, {8'd1, 8'd4, 8'd0, 8'd1});
    runInstr(16'hC87F);
    chk("mov_cycles", cycles, 8);
    chk("mov_addrLatch", nAl, 2);
    chk("mov_lines", {line0, line1}, {7'h10, 7'h7F});
    chk("mov_order", {8'(fMrd), 8'(fMwr)}, {8'd3, 8'd6});
    chk("mov_memInSel", 32'(bus.memInSel), 1);
    chk("mov_excl", nExcl, 0);
    bus.instruction = 16'h0392;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("wb_before_rst", 32'(bus.writeEn), 1);
    #1 resetN = 1'b0;
    #1;
    chk("rst_mid_writeEn", 32'(bus.writeEn), 0);
    chk("rst_mid_hold", 32'(bus.hold), 1);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 0);
    runInstr(16'h0392);
    chk("post_rst_cycles", cycles, 8);
    chk("post_rst_wr_at", fWr, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
